// File: rtl/w450_cpu.sv
// w450 8-bit two-state (FETCH/EXEC) load/store core driving a 256x8 memory.
// Optional `W450_MUL_EN turns opcode 0 from NOP into MUL (rd <- low byte of rd*rs).
module w450_cpu #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    output logic [n-1:0] mem_wr_data,
    output logic [n-1:0] mem_wr_addr,
    output logic         mem_wr_en,
    input  logic [n-1:0] mem_rd_data1,
    output logic [n-1:0] mem_rd_addr1,
    input  logic [n-1:0] mem_rd_data2,
    output logic [n-1:0] mem_rd_addr2
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JNZ  = 4'hC;
    localparam logic [3:0] OP_LDR  = 4'hD;
    localparam logic [3:0] OP_STR  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [n-1:0] ONE = n'(1);
    localparam logic [n-1:0] TWO = n'(2);

    state_t       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic [n-1:0] ir_q, ir_d;
    logic [n-1:0] opr_q, opr_d;
    logic [n-1:0] regs_q [4];
    logic [n-1:0] regs_d [4];

    logic [3:0]   op;
    logic [1:0]   rd_sel;
    logic [1:0]   rs_sel;
    logic [n-1:0] rd_val;
    logic [n-1:0] rs_val;

    assign op     = ir_q[7:4];
    assign rd_sel = ir_q[3:2];
    assign rs_sel = ir_q[1:0];
    assign rd_val = regs_q[rd_sel];
    assign rs_val = regs_q[rs_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            opr_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        opr_d        = opr_q;
        regs_d       = regs_q;
        mem_wr_en    = 1'b0;
        mem_wr_addr  = '0;
        mem_wr_data  = '0;
        mem_rd_addr1 = pc_q;
        mem_rd_addr2 = pc_q + ONE;

        unique case (state_q)
            FETCH: begin
                ir_d    = mem_rd_data1;
                opr_d   = mem_rd_data2;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + TWO;
                case (op)
`ifdef W450_MUL_EN
                    OP_NOP:  regs_d[rd_sel] = rd_val * rs_val;
`endif
                    OP_LDI:  regs_d[rd_sel] = opr_q;
                    OP_LD: begin
                        mem_rd_addr2   = opr_q;
                        regs_d[rd_sel] = mem_rd_data2;
                    end
                    OP_ST: begin
                        mem_wr_en   = 1'b1;
                        mem_wr_addr = opr_q;
                        mem_wr_data = rd_val;
                    end
                    OP_ADD:  regs_d[rd_sel] = rd_val + rs_val;
                    OP_SUB:  regs_d[rd_sel] = rd_val - rs_val;
                    OP_AND:  regs_d[rd_sel] = rd_val & rs_val;
                    OP_OR:   regs_d[rd_sel] = rd_val | rs_val;
                    OP_XOR:  regs_d[rd_sel] = rd_val ^ rs_val;
                    OP_ADDI: regs_d[rd_sel] = rd_val + opr_q;
                    OP_JMP:  pc_d = opr_q;
                    OP_JZ:   if (rd_val == '0) pc_d = opr_q;
                    OP_JNZ:  if (rd_val != '0) pc_d = opr_q;
                    OP_LDR: begin
                        mem_rd_addr2   = rs_val;
                        regs_d[rd_sel] = mem_rd_data2;
                    end
                    OP_STR: begin
                        mem_wr_en   = 1'b1;
                        mem_wr_addr = rs_val;
                        mem_wr_data = rd_val;
                    end
                    // PC stays on the HALT instruction so the read addresses freeze there.
                    OP_HALT: begin
                        state_d = HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            HALT: ;
            default: state_d = FETCH;
        endcase

        // Reset kills the bus immediately, including a store already in EXEC.
        if (reset) begin
            mem_wr_en    = 1'b0;
            mem_wr_addr  = '0;
            mem_wr_data  = '0;
            mem_rd_addr1 = '0;
            mem_rd_addr2 = ONE;
        end
    end

endmodule

// File: tb/tb_w450_cpu.sv
// Bench for w450_cpu: behavioural 256x8 memory on the falling edge, instruction-level
// reference model producing a per-cycle expected bus trace, directed and random programs.
module tb_w450_cpu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mem_wr_data, mem_wr_addr;
    logic       mem_wr_en;
    logic [7:0] mem_rd_data1 = 8'h00;
    logic [7:0] mem_rd_data2 = 8'h00;
    logic [7:0] mem_rd_addr1, mem_rd_addr2;

    logic [7:0] mem [256];
    logic [7:0] init_mem [256];
    logic [7:0] model_mem [256];
    logic       load_req = 1'b0;

    // {kind[1:0], rd_addr1, rd_addr2, wr_en, wr_addr, wr_data}
    logic [34:0] exp_q [$];
    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_EXEC  = 2'd1;
    localparam logic [1:0] K_HALT  = 2'd2;

    int total = 0;
    int bad = 0;
    int first_wr, first_done, wr_count;

    w450_cpu #(.n(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_data1 (mem_rd_data1),
        .mem_rd_addr1 (mem_rd_addr1),
        .mem_rd_data2 (mem_rd_data2),
        .mem_rd_addr2 (mem_rd_addr2)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (load_req) begin
            mem <= init_mem;
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
        mem_rd_data1 <= mem[mem_rd_addr1];
        mem_rd_data2 <= mem[mem_rd_addr2];
    end

    task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Instruction-set model: executes the program and records what the bus must show each cycle.
    task automatic build_trace(input int ncycles);
        logic [7:0] m [256];
        logic [7:0] r [4];
        logic [7:0] pc, ir, opr, nxt, wa, wd;
        logic [3:0] op;
        logic [1:0] d, s;
        logic       we, halted;
        m = init_mem;
        for (int i = 0; i < 4; i++) r[i] = 8'h00;
        pc = 8'h00;
        halted = 1'b0;
        exp_q.delete();
        while (exp_q.size() < ncycles) begin
            if (halted) begin
                exp_q.push_back({K_HALT, pc, 8'(pc + 8'd1), 1'b0, 8'h00, 8'h00});
                continue;
            end
            exp_q.push_back({K_FETCH, pc, 8'(pc + 8'd1), 1'b0, 8'h00, 8'h00});
            if (exp_q.size() >= ncycles) break;
            ir  = m[pc];
            opr = m[8'(pc + 8'd1)];
            op  = ir[7:4];
            d   = ir[3:2];
            s   = ir[1:0];
            nxt = 8'(pc + 8'd2);
            we  = 1'b0;
            wa  = 8'h00;
            wd  = 8'h00;
            case (op)
`ifdef W450_MUL_EN
                4'h0: r[d] = 8'(r[d] * r[s]);
`endif
                4'h1: r[d] = opr;
                4'h2: r[d] = m[opr];
                4'h3: begin we = 1'b1; wa = opr; wd = r[d]; end
                4'h4: r[d] = 8'(r[d] + r[s]);
                4'h5: r[d] = 8'(r[d] - r[s]);
                4'h6: r[d] = r[d] & r[s];
                4'h7: r[d] = r[d] | r[s];
                4'h8: r[d] = r[d] ^ r[s];
                4'h9: r[d] = 8'(r[d] + opr);
                4'hA: nxt = opr;
                4'hB: if (r[d] == 8'h00) nxt = opr;
                4'hC: if (r[d] != 8'h00) nxt = opr;
                4'hD: r[d] = m[r[s]];
                4'hE: begin we = 1'b1; wa = r[s]; wd = r[d]; end
                4'hF: begin halted = 1'b1; nxt = pc; end
                default: ;
            endcase
            exp_q.push_back({K_EXEC, 8'h00, 8'h00, we, wa, wd});
            if (we) m[wa] = wd;
            pc = nxt;
        end
        model_mem = m;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq(tag, 35'({mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr1, mem_rd_addr2}),
                 35'({1'b0, 8'h00, 8'h00, 8'h00, 8'h01}));
    endtask

    // Loads init_mem under reset; returns at the start (+1) of the first fetch cycle.
    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        #1 load_req = 1'b0;
        check_reset_outputs("rst_bus");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_cycles(input int ncycles);
        logic [34:0] e;
        logic [32:0] obs;
        first_wr = -1;
        first_done = -1;
        wr_count = 0;
        for (int k = 0; k < ncycles; k++) begin
            #4;
            e = exp_q.pop_front();
            obs = {mem_rd_addr1, mem_rd_addr2, mem_wr_en, mem_wr_addr, mem_wr_data};
            if (e[34:33] == K_EXEC)
                check_eq("exec_wr", 35'(obs[16:0]), 35'(e[16:0]));
            else if (e[34:33] == K_FETCH)
                check_eq("fetch_bus", 35'(obs), 35'(e[32:0]));
            else
                check_eq("halt_bus", 35'(obs), 35'(e[32:0]));
            if (mem_wr_en) begin
                wr_count++;
                if (first_wr < 0) first_wr = k + 1;
                if (mem_wr_addr == 8'hFF && mem_wr_data == 8'h01 && first_done < 0)
                    first_done = k + 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_mem_model();
        int diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) diff++;
        check_eq("mem_diff", 35'(diff), 35'(0));
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) init_mem[i] = v;
    endtask

    task automatic run_prog(input int ncycles);
        build_trace(ncycles);
        do_reset();
        run_cycles(ncycles);
        check_mem_model();
    endtask

    initial begin
        reset = 1'b1;
        #5 check_reset_outputs("rst_t0");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // LDI R1,01; LDI R2,FF; STR R1,[R2]: completion write in cycle 6
        fill(8'hF0);
        init_mem[0] = 8'h14; init_mem[1] = 8'h01;
        init_mem[2] = 8'h18; init_mem[3] = 8'hFF;
        init_mem[4] = 8'hE6; init_mem[5] = 8'h00;
        run_prog(10);
        check_eq("done_cycle", 35'(first_done), 35'(6));

        // LDI R0,F0; ADDI R0,20; ST R0,[80]; LD R3,[80]; ST R3,[81]
        fill(8'hF0);
        init_mem[0] = 8'h10; init_mem[1] = 8'hF0;
        init_mem[2] = 8'h90; init_mem[3] = 8'h20;
        init_mem[4] = 8'h30; init_mem[5] = 8'h80;
        init_mem[6] = 8'h2C; init_mem[7] = 8'h80;
        init_mem[8] = 8'h3C; init_mem[9] = 8'h81;
        run_prog(14);
        check_eq("wrap_st", 35'(mem[8'h80]), 35'(8'h10));
        check_eq("wrap_ld", 35'(mem[8'h81]), 35'(8'h10));

        // Countdown loop, store to FE (turns it into NOP), JMP FE wraps PC to 00
        fill(8'hF0);
        init_mem[0] = 8'h10; init_mem[1] = 8'h03;
        init_mem[2] = 8'h90; init_mem[3] = 8'hFF;
        init_mem[4] = 8'hC0; init_mem[5] = 8'h02;
        init_mem[6] = 8'h30; init_mem[7] = 8'hFE;
        init_mem[8] = 8'hA0; init_mem[9] = 8'hFE;
        run_prog(26);
        check_eq("loop_first_wr", 35'(first_wr), 35'(16));
        check_eq("loop_mem_fe", 35'(mem[8'hFE]), 35'(8'h00));

        // HALT then idle
        fill(8'h00);
        init_mem[0] = 8'hF0;
        run_prog(22);
        check_eq("halt_wr_count", 35'(wr_count), 35'(0));

        // Reset during EXEC of ST: no write, restart from PC=0
        fill(8'hF0);
        init_mem[0] = 8'h10; init_mem[1] = 8'h55;
        init_mem[2] = 8'h30; init_mem[3] = 8'h40;
        init_mem[8'h40] = 8'hAA;
        do_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #4 check_reset_outputs("rst_in_st");
        @(posedge clk);
        #1 reset = 1'b0;
        #4 check_eq("post_rst_fetch", 35'({mem_rd_addr1, mem_wr_en}), 35'({8'h00, 1'b0}));
        @(negedge clk);
        #1 check_eq("rst_st_no_write", 35'(mem[8'h40]), 35'(8'hAA));

        // Random programs against the model
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
            for (int i = 0; i < 64; i += 2)
                init_mem[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
            run_prog(150);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w450_cpu.md
# w450_cpu

The w450 is an 8-bit, two-state (FETCH/EXEC) load/store processor core. It sits between the clock/reset source and a 256×8 memory with one write port and two read ports. The memory is clocked on the inverted core clock, so its reads and writes complete mid-cycle. The program signals completion by writing 0x01 to address 0xFF.

## Interface
- Parameter `n`, default 8: data and address width (only n=8 is supported).
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `mem_wr_data`  out  8  store data.
- `mem_wr_addr`  out  8  store address.
- `mem_wr_en`  out  1  store strobe.
- `mem_rd_data1`  in  8  read port 1 data (instruction byte).
- `mem_rd_addr1`  out  8  read port 1 address.
- `mem_rd_data2`  in  8  read port 2 data (operand or load data).
- `mem_rd_addr2`  out  8  read port 2 address.

## Operation
- Architectural state:
  - PC (8 bits).
  - Registers R0–R3 (8 bits each).
  - IR and OPR latches (8 bits each).
  - state ∈ {FETCH, EXEC, HALT}.
- Instructions are 2 bytes:
  - Byte 0 = {op[7:4], rd[3:2], rs[1:0]}.
  - Byte 1 = imm/addr.
- FETCH:
  - rd_addr1 = PC, rd_addr2 = PC+1 (mod 256).
  - At the clock edge: IR ← rd_data1, OPR ← rd_data2, go to EXEC.
- EXEC executes IR and sets PC ← PC+2 unless a jump is taken, then returns to FETCH (HALT goes to the HALT state).
- Opcodes:
  - 0: NOP (see Configuration).
  - 1 LDI: rd ← imm.
  - 2 LD: rd ← mem[addr].
  - 3 ST: mem[addr] ← rd.
  - 4 ADD: rd ← rd+rs.
  - 5 SUB: rd ← rd−rs.
  - 6 AND, 7 OR, 8 XOR: rd ← rd op rs.
  - 9 ADDI: rd ← rd+imm.
  - A JMP: PC ← addr.
  - B JZ: PC ← addr if rd==0.
  - C JNZ: PC ← addr if rd≠0.
  - D LDR: rd ← mem[rs].
  - E STR: mem[rs] ← rd.
  - F HALT.
- Loads (LD/LDR) drive rd_addr2 with the effective address during EXEC and capture rd_data2 at the end of EXEC.
- Stores (ST/STR) assert mem_wr_en with wr_addr/wr_data combinationally during EXEC.
- When mem_wr_en=0, mem_wr_addr and mem_wr_data are forced to 0x00, so a write of 0x01 to 0xFF appears on the bus only when a real store occurs.
- Arithmetic is 8-bit modulo 256; there are no flags or carry. PC increments wrap (0xFE+2 → 0x00).
- HALT state: no writes; PC, registers and read addresses frozen. Only reset exits HALT.
- Read addresses are unspecified-but-stable in EXEC for non-load instructions; drive rd_addr1 = PC and rd_addr2 = PC+1.

## Timing
- Every instruction takes exactly 2 cycles: FETCH then EXEC.
- Memory samples read addresses and write strobes on the falling clk edge. Read data is valid at the next rising edge, so read latency seen by the core is within the same cycle.
- A store in EXEC is visible to the next FETCH (self-modifying code works).
- Reset, sampled on a rising edge, sets:
  - PC=0, R0–R3=0, IR=OPR=0, state=FETCH.
  - mem_wr_en=0, wr_addr=wr_data=0, rd_addr1=0x00, rd_addr2=0x01.
- Reset overrides any instruction in progress, including a store in EXEC; the write strobe drops in the same cycle.
- The first fetch is the cycle after reset deasserts.

## Configuration
- `W450_MUL_EN` defined: opcode 0 = MUL, rd ← low 8 bits of rd×rs, 2 cycles.
- `W450_MUL_EN` undefined: opcode 0 = NOP; only PC advances.

## Test plan
- Reset held 30 time units (clk period 20) → mem_wr_en=0, wr_addr=wr_data=0, rd_addr1=0x00 throughout reset; first fetch is from 0x00.
- Program `LDI R1,01; LDI R2,FF; STR R1,[R2]` → wr_en=1, addr=0xFF, data=0x01 in the EXEC of the 3rd instruction (6th cycle after reset); the bench finishes.
- `LDI R0,F0; ADDI R0,20; ST R0,[80]; LD R3,[80]` → mem[0x80]=0x10, R3=0x10 (wraparound verified).
- Loop `LDI R0,03; L: ADDI R0,FF; JNZ R0,L; ST R0,[FE]` → 3 iterations, then mem[0xFE]=0x00; JMP to 0x00 from the end of memory works.
- `HALT` then 20 cycles → no wr_en pulses; rd_addr1 constant.
- Reset asserted during the EXEC of an ST → no write reaches memory; PC=0 after release.
